user_mgr_obi_arbiter: RTL and testbench



---
 rtl/user_mgr_obi_arbiter.sv | 159 +++++++++++++++
 tb/tb_user_mgr_obi_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/user_mgr_obi_arbiter.sv
// Round-robin OBI arbiter sharing the user-domain manager port between NumReq managers.
// Define USER_MGR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer register).

package user_mgr_obi_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

module user_mgr_obi_arbiter #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned NumMaxTrans = 2,
  parameter type         obi_req_t   = user_mgr_obi_pkg::mgr_obi_req_t,
  parameter type         obi_rsp_t   = user_mgr_obi_pkg::mgr_obi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  obi_req_t [NumReq-1:0]   req_i,
  output obi_rsp_t [NumReq-1:0]   rsp_o,
  output obi_req_t                mgr_req_o,
  input  obi_rsp_t                mgr_rsp_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  idx_t arb_idx, sel, lock_idx, head;
  logic lock, fwd, hs, pop, fifo_full, fifo_empty, err_q;
  ptr_t wptr, rptr;
  cnt_t count, count_n;
  idx_t fifo_mem [NumMaxTrans];

  // ---------------- arbitration ----------------
`ifdef USER_MGR_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_idx = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i].req) arb_idx = idx_t'(i);
    end
  end
`else
  idx_t rr_ptr;
  int   cand;
  logic found;

  // Search upward from the pointer, wrapping at NumReq-1.
  always_comb begin
    arb_idx = rr_ptr;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < int'(NumReq); off++) begin
      cand = (int'(rr_ptr) + off) % int'(NumReq);
      if (!found && req_i[cand].req) begin
        arb_idx = idx_t'(cand);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (sel == idx_t'(NumReq - 1)) ? '0 : idx_t'(sel + 1'b1);
    end
  end
`endif

  // A stalled request keeps its requester until granted.
  assign sel = lock ? lock_idx : arb_idx;
  assign fwd = req_i[sel].req & ~fifo_full;
  assign hs  = fwd & mgr_rsp_i.gnt;

  always_comb begin
    mgr_req_o     = req_i[sel];
    mgr_req_o.req = fwd;
  end

  // ---------------- index FIFO ----------------
  assign fifo_empty = (count == '0);
  assign pop        = mgr_rsp_i.rvalid & ~fifo_empty;
  assign head       = fifo_mem[rptr];

  always_comb begin
    count_n = count;
    case ({hs, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (hs) fifo_mem[wptr] <= sel;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock      <= 1'b0;
      lock_idx  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lock <= fwd & ~mgr_rsp_i.gnt;
      if (fwd) lock_idx <= sel;
      if (hs)  wptr <= (wptr == ptr_t'(NumMaxTrans - 1)) ? '0 : ptr_t'(wptr + 1'b1);
      if (pop) rptr <= (rptr == ptr_t'(NumMaxTrans - 1)) ? '0 : ptr_t'(rptr + 1'b1);
      count     <= count_n;
      // Registered full: a pop in the same cycle does not reopen the port.
      fifo_full <= (count_n == cnt_t'(NumMaxTrans));
      if (mgr_rsp_i.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // ---------------- response routing ----------------
  always_comb begin
    rsp_o = '0;
    rsp_o[sel].gnt = hs;
    if (pop) begin
      rsp_o[head].rvalid = 1'b1;
      rsp_o[head].r      = mgr_rsp_i.r;
    end
  end

  assign busy_o = (count != '0) | lock;
  assign err_o  = err_q;

endmodule

// File: tb/tb_user_mgr_obi_arbiter.sv
// Directed bench for user_mgr_obi_arbiter (NumReq=2, NumMaxTrans=2).
module tb_user_mgr_obi_arbiter;
  import user_mgr_obi_pkg::*;

  logic               clk, rst_n;
  mgr_obi_req_t [1:0] req;
  mgr_obi_rsp_t [1:0] rsp;
  mgr_obi_req_t       mreq;
  mgr_obi_rsp_t       mrsp;
  logic               busy, err;
  int                 checks = 0;
  int                 errors = 0;

  user_mgr_obi_arbiter #(.NumReq(2), .NumMaxTrans(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rsp_o(rsp),
    .mgr_req_o(mreq), .mgr_rsp_i(mrsp), .busy_o(busy), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req  = '0;
    mrsp = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    #1;
    checks++; if (mreq !== '0) begin errors++; $display("FAIL reset_mreq: got %h exp 0", mreq); end
    checks++; if (rsp !== '0) begin errors++; $display("FAIL reset_rsp: got %h exp 0", rsp); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
  endtask

  task automatic test_single;
    req[1].req = 1'b1; req[1].a.addr = 32'h2000_0010;
    #1;
    checks++; if (mreq.req !== 1'b1 || mreq.a.addr !== 32'h2000_0010) begin errors++; $display("FAIL single_fwd: got req=%b addr=%h exp req=1 addr=20000010", mreq.req, mreq.a.addr); end
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b00) begin errors++; $display("FAIL single_nognt: got %b exp 00", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    mrsp.gnt = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b exp 10", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    tick();
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hCAFE_F00D;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b10) begin errors++; $display("FAIL single_rvalid: got %b exp 10", {rsp[1].rvalid, rsp[0].rvalid}); end
    checks++; if (rsp[1].r.rdata !== 32'hCAFE_F00D || rsp[0].r.rdata !== 32'h0) begin errors++; $display("FAIL single_rdata: got %h/%h exp cafef00d/0", rsp[1].r.rdata, rsp[0].r.rdata); end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy); end
  endtask

  task automatic test_fairness;
    int exp_w, prev;
    logic [1:0] exp_g;
    prev = 0;
    req[0].req = 1'b1; req[0].a.addr = 32'h100;
    req[1].req = 1'b1; req[1].a.addr = 32'h200;
    mrsp.gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef USER_MGR_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = i % 2;
`endif
      exp_g = (exp_w == 1) ? 2'b10 : 2'b01;
      mrsp.rvalid = (i > 0); mrsp.r.rdata = 32'(i);
      #1;
      checks++; if ({rsp[1].gnt, rsp[0].gnt} !== exp_g) begin errors++; $display("FAIL fair_gnt%0d: got %b exp %b", i, {rsp[1].gnt, rsp[0].gnt}, exp_g); end
      if (i > 0) begin
        checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== ((prev == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_route%0d: got %b exp idx %0d", i, {rsp[1].rvalid, rsp[0].rvalid}, prev); end
      end
      prev = exp_w;
      tick();
    end
    clear_inputs();
    mrsp.rvalid = 1'b1;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== ((prev == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_drain: got %b exp idx %0d", {rsp[1].rvalid, rsp[0].rvalid}, prev); end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_idle: got %b exp 0", busy); end
  endtask

  task automatic test_lock;
    // Plan case: req0 stalls while req1 waits.
    req[0].req = 1'b1; req[0].a.addr = 32'h1000_0000;
    req[1].req = 1'b1; req[1].a.addr = 32'h1000_0004;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mreq.req !== 1'b1 || mreq.a.addr !== 32'h1000_0000) begin errors++; $display("FAIL lockA_addr%0d: got %h exp 10000000", i, mreq.a.addr); end
      tick();
    end
    mrsp.gnt = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin errors++; $display("FAIL lockA_gnt0: got %b exp 01", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    req[0].req = 1'b0;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10 || mreq.a.addr !== 32'h1000_0004) begin errors++; $display("FAIL lockA_gnt1: got %b addr %h exp 10 addr 10000004", {rsp[1].gnt, rsp[0].gnt}, mreq.a.addr); end
    tick();
    clear_inputs(); mrsp.rvalid = 1'b1;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b01) begin errors++; $display("FAIL lockA_r0: got %b exp 01", {rsp[1].rvalid, rsp[0].rvalid}); end
    tick();
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b10) begin errors++; $display("FAIL lockA_r1: got %b exp 10", {rsp[1].rvalid, rsp[0].rvalid}); end
    tick();
    // A lower index arriving during a stall must not steal the port.
    clear_inputs();
    req[1].req = 1'b1; req[1].a.addr = 32'h1000_0004;
    #1;
    checks++; if (mreq.a.addr !== 32'h1000_0004) begin errors++; $display("FAIL lockB_first: got %h exp 10000004", mreq.a.addr); end
    tick();
    req[0].req = 1'b1; req[0].a.addr = 32'h1000_0000;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lockB_busy: got %b exp 1", busy); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (mreq.a.addr !== 32'h1000_0004 || {rsp[1].gnt, rsp[0].gnt} !== 2'b00) begin errors++; $display("FAIL lockB_hold%0d: got %h gnt %b exp 10000004 gnt 00", i, mreq.a.addr, {rsp[1].gnt, rsp[0].gnt}); end
      tick();
    end
    mrsp.gnt = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10) begin errors++; $display("FAIL lockB_gnt1: got %b exp 10", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    req[1].req = 1'b0;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin errors++; $display("FAIL lockB_gnt0: got %b exp 01", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    clear_inputs(); mrsp.rvalid = 1'b1;
    tick(); tick();
    clear_inputs();
  endtask

  task automatic test_backpressure;
    req[0].req = 1'b1; mrsp.gnt = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin errors++; $display("FAIL bp_gnt0: got %b exp 01", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    req[0].req = 1'b0; req[1].req = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10) begin errors++; $display("FAIL bp_gnt1: got %b exp 10", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    req[1].req = 1'b0; req[0].req = 1'b1;
    #1;
    checks++; if (mreq.req !== 1'b0 || {rsp[1].gnt, rsp[0].gnt} !== 2'b00) begin errors++; $display("FAIL bp_full: got req=%b gnt=%b exp req=0 gnt=00", mreq.req, {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hAAAA_0001;
    #1;
    checks++; if (mreq.req !== 1'b0) begin errors++; $display("FAIL bp_popcycle: got req=%b exp 0", mreq.req); end
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b01 || rsp[0].r.rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_route: got %b %h exp 01 aaaa0001", {rsp[1].rvalid, rsp[0].rvalid}, rsp[0].r.rdata); end
    tick();
    mrsp.rvalid = 1'b0;
    #1;
    checks++; if (mreq.req !== 1'b1 || {rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin errors++; $display("FAIL bp_resume: got req=%b gnt=%b exp req=1 gnt=01", mreq.req, {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    clear_inputs(); mrsp.rvalid = 1'b1;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b10) begin errors++; $display("FAIL bp_drain1: got %b exp 10", {rsp[1].rvalid, rsp[0].rvalid}); end
    tick();
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b01) begin errors++; $display("FAIL bp_drain0: got %b exp 01", {rsp[1].rvalid, rsp[0].rvalid}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_out_of_order;
    req[1].req = 1'b1; mrsp.gnt = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10) begin errors++; $display("FAIL ooo_g1: got %b exp 10", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    req[1].req = 1'b0; req[0].req = 1'b1;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b01) begin errors++; $display("FAIL ooo_g0: got %b exp 01", {rsp[1].gnt, rsp[0].gnt}); end
    tick();
    clear_inputs(); mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'd1;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b10 || rsp[1].r.rdata !== 32'd1) begin errors++; $display("FAIL ooo_d1: got %b %h exp 10 1", {rsp[1].rvalid, rsp[0].rvalid}, rsp[1].r.rdata); end
    tick();
    req[1].req = 1'b1; mrsp.gnt = 1'b1; mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'd2;
    #1;
    checks++; if ({rsp[1].gnt, rsp[0].gnt} !== 2'b10) begin errors++; $display("FAIL ooo_g1b: got %b exp 10", {rsp[1].gnt, rsp[0].gnt}); end
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b01 || rsp[0].r.rdata !== 32'd2) begin errors++; $display("FAIL ooo_d2: got %b %h exp 01 2", {rsp[1].rvalid, rsp[0].rvalid}, rsp[0].r.rdata); end
    tick();
    clear_inputs(); mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'd3;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b10 || rsp[1].r.rdata !== 32'd3) begin errors++; $display("FAIL ooo_d3: got %b %h exp 10 3", {rsp[1].rvalid, rsp[0].rvalid}, rsp[1].r.rdata); end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ooo_idle: got busy=%b err=%b exp 0 0", busy, err); end
  endtask

  task automatic test_orphan;
    mrsp.rvalid = 1'b1; mrsp.r.rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if ({rsp[1].rvalid, rsp[0].rvalid} !== 2'b00) begin errors++; $display("FAIL orphan_drop: got %b exp 00", {rsp[1].rvalid, rsp[0].rvalid}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b exp 1", err); end
    tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b exp 1", err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL orphan_clear: got err=%b busy=%b exp 0 0", err, busy); end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_backpressure();
    test_out_of_order();
    test_orphan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
